// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the state type for the single-word DMA copy engine.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_A = 3'd1,
        ST_RD_D = 3'd2,
        ST_WR_A = 3'd3,
        ST_WR_D = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } dma_state_t;

endpackage

// File: rtl/ahb_dma_copy.sv
// AHB-Lite master that copies len_words 32-bit words from src to dst, one
// SINGLE read followed by one SINGLE write per word.
module ahb_dma_copy
    import ahb_pkg::*;
#(
    parameter int AW = 32,
    parameter int LW = 16
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [LW-1:0] len_words,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [AW-1:0] HADDR,
    output logic [1:0]    HTRANS,
    output logic          HWRITE,
    output logic [2:0]    HSIZE,
    output logic [2:0]    HBURST,
    output logic [31:0]   HWDATA,
    input  logic [31:0]   HRDATA,
    input  logic          HREADY,
    input  logic          HRESP
);

    localparam logic [AW-1:0] ALIGN_MASK = {{(AW-2){1'b1}}, 2'b00};
    localparam logic [AW-1:0] WORD_STEP  = {{(AW-3){1'b0}}, 3'b100};
    localparam logic [LW-1:0] COUNT_ZERO = {LW{1'b0}};
    localparam logic [LW-1:0] COUNT_ONE  = {{(LW-1){1'b0}}, 1'b1};

    dma_state_t    state_r;
    logic [AW-1:0] src_r;
    logic [AW-1:0] dst_r;
    logic [LW-1:0] count_r;
    logic [31:0]   data_r;
    logic          busy_r;
    logic          done_r;
    logic          error_r;
    logic [AW-1:0] haddr_r;
    logic [1:0]    htrans_r;
    logic          hwrite_r;

    // Copy FSM; bus outputs are registered alongside the state so that they
    // always describe the phase the FSM is currently in.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_r  <= ST_IDLE;
            src_r    <= {AW{1'b0}};
            dst_r    <= {AW{1'b0}};
            count_r  <= COUNT_ZERO;
            data_r   <= 32'h0000_0000;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            error_r  <= 1'b0;
            haddr_r  <= {AW{1'b0}};
            htrans_r <= HTRANS_IDLE;
            hwrite_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        error_r <= 1'b0;
                        busy_r  <= 1'b1;
                        if (len_words != COUNT_ZERO) begin
                            src_r    <= src_addr & ALIGN_MASK;
                            dst_r    <= dst_addr & ALIGN_MASK;
                            count_r  <= len_words;
                            haddr_r  <= src_addr & ALIGN_MASK;
                            hwrite_r <= 1'b0;
                            htrans_r <= HTRANS_NONSEQ;
                            state_r  <= ST_RD_A;
                        end else begin
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_RD_A: begin
                    if (HREADY) begin
                        htrans_r <= HTRANS_IDLE;
                        state_r  <= ST_RD_D;
                    end
                end
                ST_RD_D: begin
                    // An error response ends the copy on its first cycle.
                    if (HRESP) begin
                        error_r <= 1'b1;
                        state_r <= ST_ERR;
                    end else if (HREADY) begin
                        data_r   <= HRDATA;
                        haddr_r  <= dst_r;
                        hwrite_r <= 1'b1;
                        htrans_r <= HTRANS_NONSEQ;
                        state_r  <= ST_WR_A;
                    end
                end
                ST_WR_A: begin
                    if (HREADY) begin
                        htrans_r <= HTRANS_IDLE;
                        state_r  <= ST_WR_D;
                    end
                end
                ST_WR_D: begin
                    if (HRESP) begin
                        error_r <= 1'b1;
                        state_r <= ST_ERR;
                    end else if (HREADY) begin
                        src_r   <= src_r + WORD_STEP;
                        dst_r   <= dst_r + WORD_STEP;
                        count_r <= count_r - COUNT_ONE;
                        if (count_r == COUNT_ONE) begin
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            haddr_r  <= src_r + WORD_STEP;
                            hwrite_r <= 1'b0;
                            htrans_r <= HTRANS_NONSEQ;
                            state_r  <= ST_RD_A;
                        end
                    end
                end
                ST_DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                ST_ERR: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r   <= 1'b0;
                    htrans_r <= HTRANS_IDLE;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign error  = error_r;
    assign HADDR  = haddr_r;
    assign HTRANS = htrans_r;
    assign HWRITE = hwrite_r;
    assign HSIZE  = HSIZE_WORD;
    assign HBURST = HBURST_SINGLE;
    assign HWDATA = data_r;

endmodule

// File: tb/tb_ahb_dma_copy.sv
// Bench for ahb_dma_copy: behavioural AHB-Lite memory slave with wait/error
// injection, plus a word-by-word reference copy model and address trace.
module tb_ahb_dma_copy;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len_words;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    always #5 HCLK = ~HCLK;

    ahb_dma_copy #(.AW(32), .LW(16)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .start(start), .src_addr(src_addr),
        .dst_addr(dst_addr), .len_words(len_words), .busy(busy), .done(done),
        .error(error), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADY(HREADY), .HRESP(HRESP)
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Slave memory (4 KB, addresses alias modulo 4 KB) and reference copy.
    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic        mem_init_r = 1'b0;
    logic        dp_valid = 1'b0, dp_write = 1'b0, dp_err = 1'b0, dp_estage = 1'b0;
    logic [31:0] dp_addr = 32'h0;
    int          dp_wait = 0;
    int          rd_count = 0, waits_total = 0, alog_n = 0, done_cnt = 0;
    logic [32:0] alog [0:2047];
    logic [32:0] exp_q [$];
    int          rd_wait_max = 0, wr_wait_max = 0, err_idx = 0;
    bit          rand_wait = 1'b0;

    function automatic int pick_wait(input int mx);
        return rand_wait ? int'($urandom_range(mx, 0)) : mx;
    endfunction

    // Slave response for the current data phase.
    always_comb begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = 32'h0000_0000;
        if (dp_valid) begin
            if (dp_err) begin
                HREADY = dp_estage;
                HRESP  = 1'b1;
            end else begin
                HREADY = (dp_wait == 0);
                if (!dp_write) HRDATA = mem[dp_addr[11:2]];
            end
        end
    end

    // Slave pipeline: finish the data phase, then accept a new address phase.
    always @(posedge HCLK) begin
        if (!mem_init_r) begin
            for (int i = 0; i < 1024; i++) mem[i] <= (i < 256) ? 32'(i * 4) : $urandom;
            mem_init_r <= 1'b1;
        end else begin
            if (dp_valid) begin
                if (dp_err) begin
                    if (dp_estage) dp_valid <= 1'b0;
                    else dp_estage <= 1'b1;
                end else if (dp_wait != 0) begin
                    dp_wait     <= dp_wait - 1;
                    waits_total <= waits_total + 1;
                end else begin
                    if (dp_write) mem[dp_addr[11:2]] <= HWDATA;
                    dp_valid <= 1'b0;
                end
            end
            if (HREADY && HTRANS == 2'b10 && !HRESET) begin
                dp_valid  <= 1'b1;
                dp_addr   <= HADDR;
                dp_write  <= HWRITE;
                dp_wait   <= pick_wait(HWRITE ? wr_wait_max : rd_wait_max);
                dp_err    <= !HWRITE && (rd_count + 1 == err_idx);
                dp_estage <= 1'b0;
                rd_count  <= rd_count + (HWRITE ? 0 : 1);
                alog[alog_n % 2048] <= {HWRITE, HADDR};
                alog_n    <= alog_n + 1;
            end
        end
    end

    // Every-cycle bus rules and wait-state address hold.
    always @(negedge HCLK) begin
        check("bus_fixed", {(HTRANS == 2'b00) || (HTRANS == 2'b10), HSIZE, HBURST, HADDR[1:0]},
              {1'b1, 3'b010, 3'b000, 2'b00});
        if (dp_valid && !HREADY)
            check("wait_hold", {HTRANS, HWRITE, HADDR}, {2'b00, dp_write, dp_addr});
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic expect_copy(input logic [31:0] s, input logic [31:0] d, input int nw, input int nwritten);
        logic [31:0] a_s, a_d;
        for (int i = 0; i < nw; i++) begin
            a_s = (s & 32'hFFFF_FFFC) + 32'(4 * i);
            a_d = (d & 32'hFFFF_FFFC) + 32'(4 * i);
            exp_q.push_back({1'b0, a_s});
            exp_q.push_back({1'b1, a_d});
            if (i < nwritten) ref_mem[a_d[11:2]] = ref_mem[a_s[11:2]];
        end
    endtask

    task automatic check_log(input int base);
        int n, bad;
        n = alog_n - base;
        bad = 0;
        check("xfer_count", n, exp_q.size());
        for (int i = 0; i < n && i < exp_q.size(); i++)
            if (alog[(base + i) % 2048] !== exp_q[i]) bad++;
        check("xfer_addr", bad, 0);
    endtask

    task automatic check_mem();
        int bad;
        bad = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
        check("mem_image", bad, 0);
    endtask

    task automatic drive_busy_start(input bit hold);
        if (hold) begin
            start     = 1'b1;
            src_addr  = $urandom;
            dst_addr  = $urandom;
            len_words = 16'($urandom_range(8, 0));
        end else begin
            start = 1'b0;
        end
    endtask

    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                            input bit hold, input bit exp_err, output int cyc, output int waits);
        int w0;
        @(negedge HCLK);
        src_addr = s; dst_addr = d; len_words = n; start = 1'b1;
        w0 = waits_total;
        @(negedge HCLK);
        drive_busy_start(hold);
        check("busy_after_start", busy, 1'b1);
        cyc = 0;
        while (!(done || error) && cyc < 4000) begin
            cyc++;
            @(negedge HCLK);
            drive_busy_start(hold);
        end
        start = 1'b0;
        check("end_state", {done, error}, exp_err ? 2'b01 : 2'b10);
        waits = waits_total - w0;
    endtask

    task automatic copy_and_check(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                                  input bit hold, output int cyc);
        int base, d0, waits;
        base = alog_n;
        d0 = done_cnt;
        exp_q.delete();
        expect_copy(s, d, int'(n), int'(n));
        run_copy(s, d, n, hold, 1'b0, cyc, waits);
        check("cycles", cyc, 4 * int'(n) + waits);
        @(negedge HCLK);
        check("post_idle", {busy, done, error}, 3'b000);
        check("done_pulses", done_cnt - d0, 1);
        check_log(base);
        check_mem();
    endtask

    initial begin
        int cyc, waits, base, d0, nwa;
        logic [31:0] s, d;
        HRESET = 1'b0;
        start = 1'b0; src_addr = 32'h0; dst_addr = 32'h0; len_words = 16'h0;
        #1 HRESET = 1'b1;
        repeat (2) @(negedge HCLK);
        check("reset_ctrl", {busy, done, error, HTRANS, HWRITE}, 6'b000000);
        check("reset_bus", {HADDR, HWDATA}, 64'h0);
        HRESET = 1'b0;
        @(negedge HCLK);
        for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];

        // Zero-wait 3-word copy.
        copy_and_check(32'h100, 32'h200, 16'd3, 1'b0, cyc);
        check("run_zero_wait", cyc, 12);
        check("word0", mem[128], 32'h100);
        check("word1", mem[129], 32'h104);
        check("word2", mem[130], 32'h108);

        // One write wait state per word.
        wr_wait_max = 1;
        copy_and_check(32'h100, 32'h240, 16'd3, 1'b0, cyc);
        check("run_wr_wait", cyc, 15);
        wr_wait_max = 0;

        // Zero length.
        copy_and_check(32'h123, 32'h456, 16'd0, 1'b0, cyc);
        check("len0_cycles", cyc, 0);

        // Error on the second read; the next start clears error.
        err_idx = rd_count + 2;
        base = alog_n;
        d0 = done_cnt;
        exp_q.delete();
        expect_copy(32'h100, 32'h380, 1, 1);
        exp_q.push_back({1'b0, 32'h104});
        run_copy(32'h100, 32'h380, 16'd3, 1'b0, 1'b1, cyc, waits);
        check("err_cycles", cyc, 6);
        repeat (3) @(negedge HCLK);
        check("err_sticky", {busy, done, error}, 3'b001);
        check("err_no_done", done_cnt - d0, 0);
        check_log(base);
        check_mem();
        err_idx = 0;
        copy_and_check(32'h500, 32'h600, 16'd0, 1'b0, cyc);

        // Address wrap at 2^32.
        copy_and_check(32'hFFFF_FFFC, 32'h300, 16'd2, 1'b0, cyc);
        check("wrap_addr", alog[(alog_n - 2) % 2048], {1'b0, 32'h0000_0000});

        // Reset in the second WR_A, with start held high while busy.
        base = alog_n;
        d0 = done_cnt;
        exp_q.delete();
        expect_copy(32'h140, 32'h3C0, 1, 1);
        exp_q.push_back({1'b0, 32'h144});
        @(negedge HCLK);
        src_addr = 32'h140; dst_addr = 32'h3C0; len_words = 16'd3; start = 1'b1;
        nwa = 0;
        cyc = 0;
        while (nwa < 2 && cyc < 200) begin
            @(negedge HCLK);
            len_words = 16'd0;
            src_addr = 32'h0;
            cyc++;
            if (HTRANS == 2'b10 && HWRITE) nwa++;
        end
        check("reached_wr_a", nwa, 2);
        start = 1'b0;
        #2 HRESET = 1'b1;
        #1;
        check("rst_mid_ctrl", {busy, done, error, HTRANS, HWRITE}, 6'b000000);
        check("rst_mid_bus", {HADDR, HWDATA}, 64'h0);
        @(negedge HCLK);
        HRESET = 1'b0;
        @(negedge HCLK);
        check("rst_after", {busy, done, error, HTRANS}, 5'b00000);
        check("rst_no_done", done_cnt - d0, 0);
        check_log(base);
        check_mem();

        // Randomized copies with random waits; some hold start high while busy.
        rand_wait = 1'b1;
        rd_wait_max = 2;
        wr_wait_max = 2;
        for (int r = 0; r < 20; r++) begin
            s = $urandom;
            d = $urandom;
            copy_and_check(s, d, 16'($urandom_range(6, 1)), 1'($urandom_range(1, 0)), cyc);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
